alu_issue_stage: RTL

Single-issue 8-bit execute/write-back stage sitting directly around the 16x8 register file (2 async read ports, 1 sync write port). It accepts instructions over a valid/ready handshake, drives the register-file read addresses, captures operands with forwarding, computes in a 2-stage pipeline (EX, WB), and drives the register-file write port. MUL is multi-cycle (shift-add, 8 cycles) and back-pressures the issuer.

---
 rtl/alu_issue_stage.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Single-issue 8-bit execute/write-back stage wrapped around a 16x8 register file.
// Operands are forwarded at accept; MUL iterates shift-add in EX and stalls the issuer.
module alu_issue_stage #(
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = 4,
  parameter int unsigned MUL_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] raddr1,
  output logic [AW-1:0] raddr2,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          flag_z,
  output logic          flag_c,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpMov = 4'd7;
  localparam logic [3:0] OpLdi = 4'd8;
  localparam logic [3:0] OpMul = 4'd9;

  // EX stage state
  logic            ex_valid_q, ex_valid_d;
  logic [3:0]      ex_op_q, ex_op_d;
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic [DW-1:0]   ex_a_q, ex_a_d;
  logic [DW-1:0]   ex_b_q, ex_b_d;
  logic [DW-1:0]   ex_imm_q, ex_imm_d;
  logic [CntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [2*DW-1:0] mul_acc_q, mul_acc_d;

  // WB stage state
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_c_q, flag_c_d;

  logic            is_mul, mul_last, ex_done, ex_writes, accept;
  logic [2*DW-1:0] mul_addend, mul_sum;
  logic [DW-1:0]   ex_res;
  logic            ex_carry;
  logic [DW-1:0]   fwd_a, fwd_b;

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  assign is_mul    = (ex_op_q == OpMul);
  assign mul_last  = (mul_cnt_q == CntW'(MUL_CYCLES - 1));
  assign ex_done   = ex_valid_q && (!is_mul || mul_last);
  assign ex_writes = (ex_op_q <= OpMul);
  assign in_ready  = !(ex_valid_q && is_mul && !mul_last);
  assign accept    = in_valid && in_ready;

  // One partial product per cycle; the final term is folded in combinationally on the last cycle.
  assign mul_addend = ex_b_q[mul_cnt_q] ? ({{DW{1'b0}}, ex_a_q} << mul_cnt_q) : '0;
  assign mul_sum    = mul_acc_q + mul_addend;

  always_comb begin
    ex_res   = '0;
    ex_carry = 1'b0;
    case (ex_op_q)
      OpAdd: {ex_carry, ex_res} = {1'b0, ex_a_q} + {1'b0, ex_b_q};
      OpSub: {ex_carry, ex_res} = {1'b0, ex_a_q} - {1'b0, ex_b_q};
      OpAnd: ex_res = ex_a_q & ex_b_q;
      OpOr:  ex_res = ex_a_q | ex_b_q;
      OpXor: ex_res = ex_a_q ^ ex_b_q;
      OpShl: begin
        ex_res   = {ex_a_q[DW-2:0], 1'b0};
        ex_carry = ex_a_q[DW-1];
      end
      OpShr: begin
        ex_res   = {1'b0, ex_a_q[DW-1:1]};
        ex_carry = ex_a_q[0];
      end
      OpMov: ex_res = ex_a_q;
      OpLdi: ex_res = ex_imm_q;
      OpMul: begin
        ex_res   = mul_sum[DW-1:0];
        ex_carry = |mul_sum[2*DW-1:DW];
      end
      default: ;
    endcase
  end

  // The completing EX result is younger than WB, so it wins.
  always_comb begin
    if (ex_done && ex_writes && (ex_rd_q == in_rs1)) begin
      fwd_a = ex_res;
    end else if (we_q && (waddr_q == in_rs1)) begin
      fwd_a = wdata_q;
    end else begin
      fwd_a = rdata1;
    end
    if (ex_done && ex_writes && (ex_rd_q == in_rs2)) begin
      fwd_b = ex_res;
    end else if (we_q && (waddr_q == in_rs2)) begin
      fwd_b = wdata_q;
    end else begin
      fwd_b = rdata2;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_imm_d   = ex_imm_q;
    mul_cnt_d  = mul_cnt_q;
    mul_acc_d  = mul_acc_q;
    if (ex_done) begin
      ex_valid_d = 1'b0;
    end
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = in_op;
      ex_rd_d    = in_rd;
      ex_a_d     = fwd_a;
      ex_b_d     = fwd_b;
      ex_imm_d   = in_imm;
      mul_cnt_d  = '0;
      mul_acc_d  = '0;
    end else if (ex_valid_q && is_mul && !mul_last) begin
      mul_cnt_d = mul_cnt_q + 1'b1;
      mul_acc_d = mul_sum;
    end
  end

  always_comb begin
    we_d     = ex_done && ex_writes;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    if (we_d) begin
      waddr_d  = ex_rd_q;
      wdata_d  = ex_res;
      flag_z_d = (ex_res == '0);
      flag_c_d = ex_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_imm_q   <= '0;
      mul_cnt_q  <= '0;
      mul_acc_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_imm_q   <= ex_imm_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_acc_q  <= mul_acc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
    end
  end

  assign we     = we_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign busy   = ex_valid_q || we_q;

endmodule
